// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32x32 register file.
// Optional write-through forwarding is selected by REGFILE_BYPASS_EN (see regfile_32x32.sv).
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int WR_COUNT_W = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic wr_count_t sat_inc(input wr_count_t v);
    return (v == '1) ? v : v + wr_count_t'(1);
  endfunction

endpackage

// File: rtl/regfile_mux32.sv
// One-bit 32-to-1 multiplexer; a read port uses one of these per data bit.
module regfile_mux32
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] bits_i,
  input  reg_addr_t           sel_i,
  output logic                bit_o
);

  assign bit_o = bits_i[sel_i];

endmodule

// File: rtl/regfile_wdec.sv
// Write decoder: turns we + waddr into a one-hot write strobe.
// Strobe bit 0 is always low so the zero register can never be written.
module regfile_wdec
  import regfile_pkg::*;
(
  input  logic                we_i,
  input  reg_addr_t           waddr_i,
  output logic [NUM_REGS-1:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    if (we_i) begin
      strobe_o[waddr_i] = 1'b1;
    end
    strobe_o[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 register file: two combinational read ports, one synchronous write port, r0 reads 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module regfile_32x32
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [7:0]        wr_count
);

  logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];
  wr_count_t           wr_count_q;
  wr_count_t           wr_count_d;
  logic [NUM_REGS-1:0] wr_strobe;
  logic [NUM_REGS-1:0] col [DATA_W];
  logic [DATA_W-1:0]   mux_a_data;
  logic [DATA_W-1:0]   mux_b_data;

  regfile_wdec u_wdec (
    .we_i     (we),
    .waddr_i  (reg_addr_t'(waddr)),
    .strobe_o (wr_strobe)
  );

  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wr_strobe[r]) begin
        regs_d[r] = wdata;
      end
    end
  end

  // The decoder already excludes r0, so any strobe bit is a committed write.
  always_comb begin
    wr_count_d = wr_count_q;
    if (|wr_strobe) begin
      wr_count_d = sat_inc(wr_count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Bit-slice the storage into per-bit columns; column entry 0 is the zero register.
  always_comb begin
    for (int b = 0; b < DATA_W; b++) begin
      col[b]    = '0;
      col[b][0] = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        col[b][r] = regs_q[r][b];
      end
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_rd_bit
    regfile_mux32 u_mux_a (
      .bits_i (col[b]),
      .sel_i  (reg_addr_t'(raddr_a)),
      .bit_o  (mux_a_data[b])
    );
    regfile_mux32 u_mux_b (
      .bits_i (col[b]),
      .sel_i  (reg_addr_t'(raddr_b)),
      .bit_o  (mux_b_data[b])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic hit_a;
  logic hit_b;

  assign wr_live = we && (reg_addr_t'(waddr) != ZERO_REG);
  assign hit_a   = wr_live && (raddr_a == waddr);
  assign hit_b   = wr_live && (raddr_b == waddr);
  assign rdata_a = hit_a ? wdata : mux_a_data;
  assign rdata_b = hit_b ? wdata : mux_b_data;
`else
  assign rdata_a = mux_a_data;
  assign rdata_b = mux_b_data;
`endif

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32: vector table plus reset, forwarding and saturation sequences.
module tb_regfile_32x32;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [7:0]  wr_count;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  regfile_32x32 dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .wr_count (wr_count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr_a  = '0;
    raddr_b  = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 8'd1};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF, 8'd1};
    vecs[2] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000, 8'd1};
    vecs[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 8'd2};
    vecs[4] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd7,  32'h80000001, 32'hA5A5A5A5, 8'd3};
    vecs[5] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd31, 32'h00000000, 32'h80000001, 8'd4};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state on every index, both ports
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      check($sformatf("reset_a[%0d]", i), rdata_a, 32'h0);
      check($sformatf("reset_b[%0d]", 31 - i), rdata_b, 32'h0);
    end
    check("reset_cnt", 32'(wr_count), 32'd0);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      we    = vecs[v].we;
      waddr = vecs[v].waddr;
      wdata = vecs[v].wdata;
      @(posedge clk);
      #1;
      we      = 1'b0;
      raddr_a = vecs[v].ra;
      raddr_b = vecs[v].rb;
      #1;
      check($sformatf("vec%0d_a", v), rdata_a, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), rdata_b, vecs[v].exp_b);
      check($sformatf("vec%0d_cnt", v), 32'(wr_count), 32'(vecs[v].exp_cnt));
    end

    // Same-cycle read of the register being written (r7 holds A5A5A5A5)
    @(negedge clk);
    we      = 1'b1;
    waddr   = 5'd7;
    wdata   = 32'h12345678;
    raddr_a = 5'd7;
    raddr_b = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle_a", rdata_a, 32'h12345678);
`else
    check("byp_same_cycle_a", rdata_a, 32'hA5A5A5A5);
`endif
    check("byp_same_cycle_r0", rdata_b, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("byp_after_edge_a", rdata_a, 32'h12345678);
    check("byp_after_edge_cnt", 32'(wr_count), 32'd5);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    raddr_a = 5'd7;
    raddr_b = 5'd31;
    reset   = 1'b1;
    #1;
    check("async_rst_a", rdata_a, 32'h0);
    check("async_rst_b", rdata_b, 32'h0);
    check("async_rst_cnt", 32'(wr_count), 32'd0);
    #1 reset = 1'b0;

    // Fill r1..r31 and read mirrored pairs
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      check($sformatf("fill_a[%0d]", i), rdata_a, 32'(i) * 32'h01010101);
      check($sformatf("fill_b[%0d]", 31 - i), rdata_b, 32'(31 - i) * 32'h01010101);
    end
    check("fill_cnt", 32'(wr_count), 32'd31);

    // Reset coinciding with a write edge: the write is lost
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd3;
    wdata = 32'hFFFFFFFF;
    @(posedge clk);
    reset = 1'b1;
    #1;
    we      = 1'b0;
    raddr_a = 5'd3;
    raddr_b = 5'd1;
    #1;
    check("edge_rst_r3", rdata_a, 32'h0);
    check("edge_rst_r1", rdata_b, 32'h0);
    check("edge_rst_cnt", 32'(wr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("edge_rst_hold_r3", rdata_a, 32'h0);

    // First write after release lands on the next edge
    do_write(5'd9, 32'h0BADF00D);
    raddr_a = 5'd9;
    #1;
    check("post_rst_r9", rdata_a, 32'h0BADF00D);
    check("post_rst_cnt", 32'(wr_count), 32'd1);

    // Counter saturation over 300 more writes
    for (int i = 0; i < 300; i++) begin
      do_write(5'((i % 31) + 1), 32'(i) * 32'h00010001);
      if (i == 252) check("sat_cnt_254", 32'(wr_count), 32'd254);
      if (i == 253) check("sat_cnt_255", 32'(wr_count), 32'd255);
    end
    check("sat_cnt_final", 32'(wr_count), 32'd255);
    raddr_a = 5'd21;
    raddr_b = 5'd21;
    #1;
    check("sat_last_a", rdata_a, 32'd299 * 32'h00010001);
    check("sat_last_b", rdata_b, 32'd299 * 32'h00010001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
